// File: rtl/core_pipe_stage_pkg.sv
// Shared pipeline-stage definitions: hold levels, reset constants and stage occupancy states.
// Holds the hold-level encodings driven by core_ctrl, the NOP instruction and CPU reset
// address used for bubbles, and the EMPTY/FULL1/FULL2 occupancy encoding.
package core_pipe_stage_pkg;

   // Hold-level bus from core_ctrl; higher values freeze more of the pipeline
   localparam int unsigned HoldFlagW = 3;

   localparam logic [HoldFlagW-1:0] HoldNone = 3'd0;
   localparam logic [HoldFlagW-1:0] HoldPc   = 3'd1;
   localparam logic [HoldFlagW-1:0] HoldIf   = 3'd2;
   localparam logic [HoldFlagW-1:0] HoldId   = 3'd3;
   localparam logic [HoldFlagW-1:0] HoldEx   = 3'd4;
   localparam logic [HoldFlagW-1:0] HoldMem  = 3'd5;
   localparam logic [HoldFlagW-1:0] HoldWb   = 3'd6;

   // addi x0, x0, 0
   localparam logic [31:0] InstNop       = 32'h0000_0013;
   localparam logic [31:0] CpuRstAddress = 32'h0000_0000;

   localparam int unsigned PipeStateW = 2;

   typedef enum logic [PipeStateW-1:0] {
      StEmpty = 2'd0,
      StFull1 = 2'd1,
      StFull2 = 2'd2
   } pipe_state_e;

endpackage

// File: rtl/core_pipe_skid.sv
// Two-entry storage for a pipeline stage.
// MAIN feeds the stage outputs; SKID catches a word accepted while MAIN is occupied.
// Ports:
//   clk            clock, rising edge
//   rst            asynchronous reset, active-low
//   load_main      write MAIN this cycle
//   main_from_skid source for MAIN: 1 = SKID entry, 0 = din
//   load_skid      write SKID from din this cycle
//   din            incoming word
//   main_data      MAIN entry contents
//   skid_data      SKID entry contents
module core_pipe_skid #(
   parameter int unsigned      WIDTH   = 64,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load_main,
   input  logic             main_from_skid,
   input  logic             load_skid,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] main_data,
   output logic [WIDTH-1:0] skid_data
);

   logic [WIDTH-1:0] main_d, main_q;
   logic [WIDTH-1:0] skid_d, skid_q;

   always_comb begin
      main_d = main_q;
      skid_d = skid_q;
      if (load_main) begin
         main_d = main_from_skid ? skid_q : din;
      end
      if (load_skid) begin
         skid_d = din;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_q <= RST_VAL;
         skid_q <= RST_VAL;
      end else begin
         main_q <= main_d;
         skid_q <= skid_d;
      end
   end

   assign main_data = main_q;
   assign skid_data = skid_q;

endmodule

// File: rtl/core_pipe_stage.sv
// Parametrised pipeline stage register carrying {addr, inst} between two core stages.
// Valid/ready handshake on both sides, 2-entry skid buffer, flush-to-NOP and a hold level.
// Optional feature macro: CORE_PIPE_PERF_EN adds saturating stall_cnt/bubble_cnt outputs.
// Ports:
//   clk, rst                    clock (rising) / asynchronous active-low reset
//   hold_flag_in                hold level from core_ctrl; stage freezes when >= HOLD_LEVEL
//   flush_in                    discard all stage contents
//   in_valid/in_ready           producer handshake, in_addr/in_inst payload
//   out_valid/out_ready         consumer handshake, out_addr/out_inst registered payload
//   stall_cnt, bubble_cnt       (CORE_PIPE_PERF_EN only) performance counters
module core_pipe_stage
   import core_pipe_stage_pkg::*;
#(
   parameter int unsigned           ADDR_W     = 32,
   parameter int unsigned           INST_W     = 32,
   parameter logic [HoldFlagW-1:0]  HOLD_LEVEL = HoldIf,
   parameter logic [ADDR_W-1:0]     RST_ADDR   = ADDR_W'(CpuRstAddress),
   parameter logic [INST_W-1:0]     RST_INST   = INST_W'(InstNop)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [HoldFlagW-1:0] hold_flag_in,
   input  logic                 flush_in,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [ADDR_W-1:0]    in_addr,
   input  logic [INST_W-1:0]    in_inst,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [ADDR_W-1:0]    out_addr,
   output logic [INST_W-1:0]    out_inst
`ifdef CORE_PIPE_PERF_EN
   ,
   output logic [31:0]          stall_cnt,
   output logic [31:0]          bubble_cnt
`endif
);

   localparam int unsigned Width = ADDR_W + INST_W;

   pipe_state_e state_q, state_d;

   logic             hold;
   logic             accept;
   logic             pop;
   logic             load_main;
   logic             main_from_skid;
   logic             load_skid;
   logic [Width-1:0] main_data;
   logic [Width-1:0] skid_data;

   assign hold = (hold_flag_in >= HOLD_LEVEL);

   // Both handshake outputs depend only on registered occupancy and the hold level
   assign in_ready  = (state_q != StFull2) && !hold;
   assign out_valid = (state_q != StEmpty) && !hold;

   assign accept = in_valid && in_ready;
   assign pop    = out_valid && out_ready;

   always_comb begin
      state_d        = state_q;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
      if (flush_in) begin
         // Entries keep stale data; the EMPTY state masks it on the outputs
         state_d = StEmpty;
      end else if (!hold) begin
         unique case (state_q)
            StEmpty: begin
               if (accept) begin
                  state_d   = StFull1;
                  load_main = 1'b1;
               end
            end
            StFull1: begin
               if (accept && pop) begin
                  load_main = 1'b1;
               end else if (accept) begin
                  state_d   = StFull2;
                  load_skid = 1'b1;
               end else if (pop) begin
                  state_d = StEmpty;
               end
            end
            StFull2: begin
               // in_ready is low here, so only a pop can move the state
               if (pop) begin
                  state_d        = StFull1;
                  load_main      = 1'b1;
                  main_from_skid = 1'b1;
               end
            end
            default: state_d = StEmpty;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StEmpty;
      end else begin
         state_q <= state_d;
      end
   end

   core_pipe_skid #(
      .WIDTH   (Width),
      .RST_VAL ({RST_ADDR, RST_INST})
   ) u_skid (
      .clk            (clk),
      .rst            (rst),
      .load_main      (load_main),
      .main_from_skid (main_from_skid),
      .load_skid      (load_skid),
      .din            ({in_addr, in_inst}),
      .main_data      (main_data),
      .skid_data      (skid_data)
   );

   // An empty stage presents a NOP bubble, never stale data
   assign {out_addr, out_inst} = (state_q == StEmpty) ? {RST_ADDR, RST_INST} : main_data;

`ifdef CORE_PIPE_PERF_EN
   logic [31:0] stall_cnt_q;
   logic [31:0] bubble_cnt_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         if (in_valid && !in_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
         end
         if (!out_valid && !hold && (bubble_cnt_q != 32'hFFFF_FFFF)) begin
            bubble_cnt_q <= bubble_cnt_q + 32'd1;
         end
      end
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_core_pipe_stage.sv
module tb_core_pipe_stage;
   import core_pipe_stage_pkg::*;

   localparam logic [31:0] K = 32'hC0DE_0000;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  hold_flag_in;
   logic        flush_in;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_addr;
   logic [31:0] in_inst;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_addr;
   logic [31:0] out_inst;
`ifdef CORE_PIPE_PERF_EN
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;
`endif

   always #5 clk = ~clk;

   core_pipe_stage dut (
      .clk          (clk),
      .rst          (rst),
      .hold_flag_in (hold_flag_in),
      .flush_in     (flush_in),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_addr      (in_addr),
      .in_inst      (in_inst),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_addr     (out_addr),
      .out_inst     (out_inst)
`ifdef CORE_PIPE_PERF_EN
      ,
      .stall_cnt    (stall_cnt),
      .bubble_cnt   (bubble_cnt)
`endif
   );

   typedef struct {
      logic        iv;
      logic [31:0] ia;
      logic [31:0] ii;
      logic        ordy;
      logic [2:0]  hf;
      logic        fl;
      logic        e_irdy;
      logic        e_ov;
      logic [31:0] e_addr;
      logic [31:0] e_inst;
   } vec_t;

   vec_t        vecs[$];
   logic [63:0] sb[$];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic iv, input logic [31:0] ia, input logic ordy,
                      input logic [2:0] hf, input logic fl, input logic e_irdy,
                      input logic e_ov, input logic e_nop, input logic [31:0] e_addr);
      vec_t v;
      v.iv     = iv;
      v.ia     = ia;
      v.ii     = K + ia;
      v.ordy   = ordy;
      v.hf     = hf;
      v.fl     = fl;
      v.e_irdy = e_irdy;
      v.e_ov   = e_ov;
      v.e_addr = e_nop ? 32'h0 : e_addr;
      v.e_inst = e_nop ? 32'h0000_0013 : K + e_addr;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic iv, input logic [31:0] ia, input logic ordy,
                        input logic [2:0] hf, input logic fl);
      in_valid     = iv;
      in_addr      = ia;
      in_inst      = K + ia;
      out_ready    = ordy;
      hold_flag_in = hf;
      flush_in     = fl;
   endtask

   // Called at the negedge: pop-compare delivered words, then record accepted ones
   task automatic step_sb();
      logic [63:0] e;
      if (out_valid && out_ready) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL sb_underflow: got %h expected nothing", {out_addr, out_inst});
         end else begin
            e = sb.pop_front();
            chk("sb_data", {out_addr, out_inst}, e);
         end
      end
      if (flush_in) sb.delete();
      else if (in_valid && in_ready) sb.push_back({in_addr, in_inst});
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic exp_hold;
      rst = 1'b0;
      drive(1'b0, 32'h0, 1'b0, HoldNone, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'h0);
      chk("rst_out_addr", 64'(out_addr), 64'h0);
      chk("rst_out_inst", 64'(out_inst), 64'h13);
      chk("rst_in_ready", 64'(in_ready), 64'h1);
      rst = 1'b1;
      next_cycle();

      // iv, addr, ordy, hold, flush | in_ready, out_valid, nop, addr
      add(1, 32'h00, 1, 0, 0, 1, 0, 1, 0);
      add(1, 32'h04, 1, 0, 0, 1, 1, 0, 32'h00);
      add(1, 32'h08, 1, 0, 0, 1, 1, 0, 32'h04);
      add(0, 32'h00, 1, 0, 0, 1, 1, 0, 32'h08);
      add(0, 32'h00, 1, 0, 0, 1, 0, 1, 0);
      add(1, 32'h10, 0, 0, 0, 1, 0, 1, 0);
      add(1, 32'h14, 0, 0, 0, 1, 1, 0, 32'h10);
      add(1, 32'h18, 0, 0, 0, 0, 1, 0, 32'h10);
      add(0, 32'h00, 1, 0, 0, 0, 1, 0, 32'h10);
      add(0, 32'h00, 1, 0, 0, 1, 1, 0, 32'h14);
      add(0, 32'h00, 1, 0, 0, 1, 0, 1, 0);
      add(1, 32'h20, 0, 0, 0, 1, 0, 1, 0);
      add(1, 32'h24, 1, 2, 0, 0, 0, 0, 32'h20);
      add(1, 32'h24, 1, 3, 0, 0, 0, 0, 32'h20);
      add(1, 32'h24, 1, 7, 0, 0, 0, 0, 32'h20);
      add(0, 32'h00, 1, 0, 0, 1, 1, 0, 32'h20);
      add(0, 32'h00, 1, 0, 0, 1, 0, 1, 0);
      add(1, 32'h30, 0, 0, 0, 1, 0, 1, 0);
      add(1, 32'h34, 0, 0, 0, 1, 1, 0, 32'h30);
      add(1, 32'h38, 0, 0, 1, 0, 1, 0, 32'h30);
      add(0, 32'h00, 0, 0, 0, 1, 0, 1, 0);
      add(1, 32'h40, 0, 0, 0, 1, 0, 1, 0);
      add(0, 32'h00, 0, 2, 1, 0, 0, 0, 32'h40);
      add(0, 32'h00, 0, 0, 0, 1, 0, 1, 0);
      add(1, 32'h50, 0, 0, 0, 1, 0, 1, 0);
      add(0, 32'h00, 1, 0, 1, 1, 1, 0, 32'h50);
      add(0, 32'h00, 1, 0, 0, 1, 0, 1, 0);
      add(1, 32'h60, 1, 1, 0, 1, 0, 1, 0);
      add(0, 32'h00, 1, 1, 0, 1, 1, 0, 32'h60);
      add(0, 32'h00, 1, 0, 0, 1, 0, 1, 0);

      foreach (vecs[i]) begin
         drive(vecs[i].iv, vecs[i].ia, vecs[i].ordy, vecs[i].hf, vecs[i].fl);
         @(negedge clk);
         chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].e_irdy));
         chk($sformatf("v%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].e_ov));
         chk($sformatf("v%0d_out_addr", i), 64'(out_addr), 64'(vecs[i].e_addr));
         chk($sformatf("v%0d_out_inst", i), 64'(out_inst), 64'(vecs[i].e_inst));
         step_sb();
         next_cycle();
      end

      // Asynchronous reset while the stage holds two words
      drive(1'b1, 32'h70, 1'b0, HoldNone, 1'b0);
      @(negedge clk); step_sb(); next_cycle();
      drive(1'b1, 32'h74, 1'b0, HoldNone, 1'b0);
      @(negedge clk); step_sb(); next_cycle();
      chk("full2_in_ready", 64'(in_ready), 64'h0);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_out_valid", 64'(out_valid), 64'h0);
      chk("arst_out_addr", 64'(out_addr), 64'h0);
      chk("arst_out_inst", 64'(out_inst), 64'h13);
      chk("arst_in_ready", 64'(in_ready), 64'h1);
      sb.delete();
      drive(1'b0, 32'h0, 1'b0, HoldNone, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      next_cycle();

      // Random traffic: occupancy model is the scoreboard depth
      for (int c = 0; c < 400; c++) begin
         drive(1'($urandom_range(0, 1)), $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) == 0) ? HoldIf : HoldNone, $urandom_range(0, 24) == 0);
         @(negedge clk);
         exp_hold = (hold_flag_in >= HoldIf);
         chk("rnd_in_ready", 64'(in_ready), 64'((sb.size() < 2) && !exp_hold));
         chk("rnd_out_valid", 64'(out_valid), 64'((sb.size() > 0) && !exp_hold));
         if (sb.size() == 0) chk("rnd_bubble", {out_addr, out_inst}, 64'h13);
         step_sb();
         next_cycle();
      end

      drive(1'b0, 32'h0, 1'b1, HoldNone, 1'b0);
      for (int c = 0; c < 8 && sb.size() != 0; c++) begin
         @(negedge clk);
         step_sb();
         next_cycle();
      end
      chk("drain_empty", 64'(sb.size()), 64'h0);

`ifdef CORE_PIPE_PERF_EN
      rst = 1'b0;
      #2;
      chk("perf_rst_stall", 64'(stall_cnt), 64'h0);
      chk("perf_rst_bubble", 64'(bubble_cnt), 64'h0);
      drive(1'b0, 32'h0, 1'b0, HoldNone, 1'b0);
      @(negedge clk);
      rst = 1'b1;
      // Cycle 0 is the only bubble; cycles 2..6 stall against a full stage
      for (int c = 0; c < 7; c++) begin
         drive(1'b1, 32'h80 + 32'(c * 4), 1'b0, HoldNone, 1'b0);
         next_cycle();
      end
      drive(1'b0, 32'h0, 1'b0, HoldNone, 1'b0);
      @(negedge clk);
      chk("perf_stall5", 64'(stall_cnt), 64'd5);
      chk("perf_bubble1", 64'(bubble_cnt), 64'd1);
      dut.stall_cnt_q = 32'hFFFF_FFFF;
      drive(1'b1, 32'h0, 1'b0, HoldNone, 1'b0);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, HoldNone, 1'b0);
      @(negedge clk);
      chk("perf_stall_sat", 64'(stall_cnt), 64'hFFFF_FFFF);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
